// File: rtl/sd_adc_rx.sv
// Sigma-delta ADC receiver: synchronises cmp_in, drives fb_out, boxcar-decimates fb_out over OSR clocks.
// Latency: cmp_in->fb_out 3 edges; window end->sample_valid 1 edge. Optional SD_ADC_MAVG4_EN: 4-tap moving average.
// Backpressure: a result arriving while an unaccepted sample is held is dropped and sets sticky overrun.
module sd_adc_rx #(
    parameter int FREQ       = 8_000_000,
    parameter int OSR        = 256,
    parameter int SETTLE_WIN = 4,
    localparam int OUT_W     = $clog2(OSR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmp_in,
    output logic             fb_out,
    output logic [OUT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             settled
);

    if (OSR < 4 || (OSR & (OSR - 1)) != 0 || SETTLE_WIN < 0 || SETTLE_WIN > 255 || FREQ <= 0)
    begin : g_param_err
        $error("sd_adc_rx: illegal parameter set");
    end

    typedef enum logic {ST_SETTLE, ST_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_s1;
    logic               r_s2;
    logic               r_fb;
    logic [OUT_W-1:0]   r_win_ctr;
    logic [OUT_W:0]     r_acc;
    logic [7:0]         r_settle_ctr;
    logic [OUT_W-1:0]   r_data;
    logic               r_valid;
    logic               r_ovr;

    logic               w_win_end;
    logic [OUT_W:0]     w_sum;
    logic [OUT_W-1:0]   w_result;
    logic               w_settle_done;
    logic               w_offer;
    logic               w_emit;
    logic [OUT_W-1:0]   w_emit_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_fb <= 1'b0;
        end else begin
            r_s1 <= cmp_in;
            r_s2 <= r_s1;
            r_fb <= r_s2;
        end
    end

    // The decimated bit is the fed-back bit, so the average tracks what the integrator sees.
    assign w_win_end     = en && (r_win_ctr == OUT_W'(OSR - 1));
    assign w_sum         = r_acc + {{OUT_W{1'b0}}, r_fb};
    assign w_result      = (w_sum == (OUT_W+1)'(OSR)) ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
    assign w_settle_done = (({1'b0, r_settle_ctr} + 9'd1) == 9'(SETTLE_WIN));
    assign w_offer       = w_win_end && (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_win_ctr    <= '0;
            r_acc        <= '0;
            r_settle_ctr <= '0;
        end else begin
            r_win_ctr <= r_win_ctr + 1'b1;
            r_acc     <= w_win_end ? '0 : w_sum;
            if (w_win_end && r_state == ST_SETTLE)
                r_settle_ctr <= r_settle_ctr + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_SETTLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_SETTLE;
        end else begin
            case (r_state)
                ST_SETTLE:
                    if (SETTLE_WIN == 0 || (w_win_end && w_settle_done))
                        w_state_nxt = ST_RUN;
                default:
                    w_state_nxt = ST_RUN;
            endcase
        end
    end

`ifdef SD_ADC_MAVG4_EN
    logic [OUT_W-1:0] r_hist [3];
    logic [1:0]       r_hist_cnt;
    logic [OUT_W+1:0] w_avg_sum;

    assign w_avg_sum  = (OUT_W+2)'(r_hist[0]) + (OUT_W+2)'(r_hist[1])
                      + (OUT_W+2)'(r_hist[2]) + (OUT_W+2)'(w_result);
    assign w_emit     = w_offer && (r_hist_cnt == 2'd3);
    assign w_emit_dat = w_avg_sum[OUT_W+1:2];

    // History only accumulates in RUN; any time spent in SETTLE restarts the average.
    always_ff @(posedge clk) begin
        if (rst || r_state == ST_SETTLE) begin
            r_hist[0]  <= '0;
            r_hist[1]  <= '0;
            r_hist[2]  <= '0;
            r_hist_cnt <= 2'd0;
        end else if (w_offer) begin
            r_hist[0]  <= w_result;
            r_hist[1]  <= r_hist[0];
            r_hist[2]  <= r_hist[1];
            if (r_hist_cnt != 2'd3)
                r_hist_cnt <= r_hist_cnt + 2'd1;
        end
    end
`else
    assign w_emit     = w_offer;
    assign w_emit_dat = w_result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_emit && (!r_valid || sample_ready)) begin
                r_data  <= w_emit_dat;
                r_valid <= 1'b1;
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_emit && r_valid && !sample_ready)
                r_ovr <= 1'b1;
            else if (overrun_clr)
                r_ovr <= 1'b0;
        end
    end

    assign fb_out       = r_fb;
    assign sample_data  = r_data;
    assign sample_valid = r_valid;
    assign overrun      = r_ovr;
    assign settled      = (r_state == ST_RUN);

endmodule
